// File: rtl/div_arb_pkg.sv
// div_arb_pkg: shared types and constants for the divider arbiter.
//   state_e      - sequencer states (IDLE, ISSUE, WAIT, RESP)
//   *_DEF        - default requester count, data width and timeout
//   id_width()   - width of an encoded requester index
//   DIV0_Q       - all-ones word; the low W bits form the divide-by-zero quotient
package div_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int NREQ_DEF    = 4;
  localparam int W_DEF       = 8;
  localparam int TIMEOUT_DEF = 64;

  localparam logic [63:0] DIV0_Q = {64{1'b1}};

  // Encoded index width; never below one bit so ports stay legal.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/div_arb_if.sv
// div_arb_if: bundles the requester, response and divider sideband signals.
//   req_valid/req_ready/req_a/req_b - per-requester operand handshake (packed)
//   rsp_valid/rsp_ready/rsp_id/rsp_q/rsp_r/rsp_err - single response channel
//   div_start/div_a/div_b/div_done/div_q/div_r - divider launch and result
//   busy - arbiter is not idle
// master: the arbiter side.  slave: clients plus divider side.
interface div_arb_if import div_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int W    = W_DEF
);
  localparam int IDW = id_width(NREQ);

  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_a;
  logic [NREQ*W-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [W-1:0]      rsp_q;
  logic [W-1:0]      rsp_r;
  logic              rsp_err;
  logic              div_start;
  logic [W-1:0]      div_a;
  logic [W-1:0]      div_b;
  logic              div_done;
  logic [W-1:0]      div_q;
  logic [W-1:0]      div_r;
  logic              busy;

  modport master (
    input  req_valid, req_a, req_b, rsp_ready, div_done, div_q, div_r,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
           div_start, div_a, div_b, busy
  );

  modport slave (
    output req_valid, req_a, req_b, rsp_ready, div_done, div_q, div_r,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_err,
           div_start, div_a, div_b, busy
  );

endinterface

// File: rtl/div_arbiter_rr.sv
// rr_arbiter: combinational round-robin grant.
//   i_req   - request vector
//   i_ptr   - highest-priority index (must be < NREQ)
//   o_grant - one-hot grant of the first request at or after i_ptr, wrapping
//   o_idx   - encoded o_grant
//   o_any   - at least one request present
module rr_arbiter import div_arb_pkg::*; #(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IDW-1:0]  i_ptr,
  output logic [NREQ-1:0] o_grant,
  output logic [IDW-1:0]  o_idx,
  output logic            o_any
);

  // Scan offsets from farthest to nearest so the nearest request wins.
  always_comb begin
    int j;
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = int'(i_ptr) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
      if (((i_req >> j) & NREQ'(1)) != '0) begin
        o_grant = NREQ'(1) << j;
        o_idx   = IDW'(j);
        o_any   = 1'b1;
      end else begin
        o_any   = o_any;
      end
    end
  end

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter: shares one divider among NREQ requesters in round-robin order.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-low reset
//   bus   - div_arb_if.master (request handshakes, response channel, divider sideband)
// Optional feature DIV_ARB_ZERO_CHECK_EN: when defined, a zero divisor skips the
// divider and answers at once with quotient all-ones, remainder = dividend, err=1.
module div_arbiter import div_arb_pkg::*; #(
  parameter int NREQ    = NREQ_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic          clk,
  input  logic          reset,
  div_arb_if.master     bus
);

  localparam int IDW = id_width(NREQ);
  localparam int CW  = $clog2(TIMEOUT + 1);
  // The counter steps once per WAIT cycle; the op aborts on the cycle it reaches TIMEOUT.
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_e         r_state;
  state_e         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [W-1:0]   r_a;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_q;
  logic [W-1:0]   r_r;
  logic           r_err;
  logic           r_done_q;
  logic [CW-1:0]  r_cnt;

  logic [NREQ-1:0] w_grant;
  logic [IDW-1:0]  w_gidx;
  logic            w_any;
  logic            w_accept;
  logic            w_done_rise;
  logic            w_timeout;
  logic [W-1:0]    w_a_sel;
  logic [W-1:0]    w_b_sel;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant),
    .o_idx   (w_gidx),
    .o_any   (w_any)
  );

  assign w_a_sel     = W'(bus.req_a >> (int'(w_gidx) * W));
  assign w_b_sel     = W'(bus.req_b >> (int'(w_gidx) * W));
  assign w_accept    = (r_state == IDLE) & w_any;
  // A done level left high by an earlier op is not a completion.
  assign w_done_rise = bus.div_done & ~r_done_q;
  assign w_timeout   = (r_cnt == CNT_LAST);

  // Ready is masked during reset so no handshake can complete while outputs are forced low.
  assign bus.req_ready = w_grant & {NREQ{(r_state == IDLE) & reset}};
  assign bus.rsp_valid = (r_state == RESP);
  assign bus.busy      = (r_state != IDLE);
  assign bus.div_start = (r_state == ISSUE);
  assign bus.div_a     = r_a;
  assign bus.div_b     = r_b;
  assign bus.rsp_id    = r_id;
  assign bus.rsp_q     = r_q;
  assign bus.rsp_r     = r_r;
  assign bus.rsp_err   = r_err;

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
`ifdef DIV_ARB_ZERO_CHECK_EN
          if (w_b_sel == '0) begin
            w_state_nxt = RESP;
          end else begin
            w_state_nxt = ISSUE;
          end
`else
          w_state_nxt = ISSUE;
`endif
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ISSUE: w_state_nxt = WAIT;
      WAIT: begin
        if (w_done_rise || w_timeout) begin
          w_state_nxt = RESP;
        end else begin
          w_state_nxt = WAIT;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Operand latch, result capture, timeout counter, done edge history and rr pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_q      <= '0;
      r_r      <= '0;
      r_err    <= 1'b0;
      r_done_q <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_done_q <= bus.div_done;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a  <= w_a_sel;
            r_b  <= w_b_sel;
            r_id <= w_gidx;
`ifdef DIV_ARB_ZERO_CHECK_EN
            if (w_b_sel == '0) begin
              r_q   <= DIV0_Q[W-1:0];
              r_r   <= w_a_sel;
              r_err <= 1'b1;
            end
`endif
          end
        end
        ISSUE: r_cnt <= '0;
        WAIT: begin
          r_cnt <= r_cnt + CW'(1);
          if (w_done_rise) begin
            r_q   <= bus.div_q;
            r_r   <= bus.div_r;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_q   <= '0;
            r_r   <= '0;
            r_err <= 1'b1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_ptr <= (r_id == IDW'(NREQ - 1)) ? '0 : r_id + IDW'(1);
          end
        end
        default: r_cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter: directed bench for div_arbiter with a latency-L divider model
// and a scoreboard of expected grants and responses.
module tb_div_arbiter;
  import div_arb_pkg::*;

  localparam int NREQ    = 4;
  localparam int W       = 8;
  localparam int TIMEOUT = 64;
  localparam int L       = 9;
  localparam int IDW     = id_width(NREQ);

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  div_arb_if #(.NREQ(NREQ), .W(W)) bus ();

  div_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Divider model: done rises L cycles after the start pulse and stays high.
  logic         m_busy  = 1'b0;
  logic         m_done  = 1'b0;
  logic         m_hang  = 1'b0;
  logic         m_force = 1'b0;
  int           m_cnt   = 0;
  logic [W-1:0] m_q     = '0;
  logic [W-1:0] m_r     = '0;

  always @(posedge clk) begin
    if (!reset) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (bus.div_start) begin
      m_busy <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= L - 1;
      if (bus.div_b == '0) begin
        m_q <= '1;
        m_r <= bus.div_a;
      end else begin
        m_q <= bus.div_a / bus.div_b;
        m_r <= bus.div_a % bus.div_b;
      end
    end else if (m_busy && !m_hang) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_busy <= 1'b0;
      end
      m_cnt <= m_cnt - 1;
    end
  end

  assign bus.div_done = m_done | m_force;
  assign bus.div_q    = m_q;
  assign bus.div_r    = m_r;

  int cyc = 0, n_start = 0, last_start = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (bus.div_start) begin
      n_start    <= n_start + 1;
      last_start <= cyc;
    end
  end

  typedef struct {
    logic [IDW-1:0] id;
    logic [W-1:0]   q;
    logic [W-1:0]   r;
    logic           err;
  } exp_t;

  exp_t exp_q[$];
  int   grant_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_op(input int id, input int q, input int r, input bit err);
    exp_t e;
    e.id  = id[IDW-1:0];
    e.q   = q[W-1:0];
    e.r   = r[W-1:0];
    e.err = err;
    grant_q.push_back(id);
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input int a, input int b);
    bus.req_a[i*W +: W] = a[W-1:0];
    bus.req_b[i*W +: W] = b[W-1:0];
    bus.req_valid[i]    = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_outputs", 64'({bus.busy, bus.rsp_valid, bus.div_start, bus.rsp_err, bus.req_ready,
                            bus.rsp_id, bus.rsp_q, bus.rsp_r, bus.div_a, bus.div_b}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // drop: 0 keep request, 1 drop granted requester, 2 drop all requesters.
  task automatic wait_accept(input int drop, output int acc);
    int id;
    int k;
    k = 0;
    #1;
    while (bus.req_ready == '0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("accept_seen", 64'(|bus.req_ready), 64'd1);
    id = (grant_q.size() > 0) ? grant_q.pop_front() : 0;
    chk("grant", 64'(bus.req_ready), 64'd1 << id);
    acc = cyc;
    @(posedge clk);
    #1;
    if (drop == 1) bus.req_valid[id] = 1'b0;
    else if (drop == 2) bus.req_valid = '0;
  endtask

  task automatic wait_rsp(output int rc);
    exp_t e;
    int   k;
    k = 0;
    #1;
    while (!bus.rsp_valid && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("rsp_seen", 64'(bus.rsp_valid), 64'd1);
    rc = cyc;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
      chk("rsp_q", 64'(bus.rsp_q), 64'(e.q));
      chk("rsp_r", 64'(bus.rsp_r), 64'(e.r));
      chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
    end
    if (bus.rsp_ready) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int acc, rc, s0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    do_reset();

    // Single request from requester 0 with latency-L divider.
    bus.rsp_ready = 1'b1;
    set_req(0, 102, 4);
    expect_op(0, 25, 2, 0);
    s0 = n_start;
    wait_accept(1, acc);
    wait_rsp(rc);
    chk("t1_latency", 64'(rc - acc), 64'(L + 2));
    chk("t1_start_at", 64'(last_start - acc), 64'd1);
    chk("t1_start_cnt", 64'(n_start - s0), 64'd1);

    // Round robin with all requesters pending from reset.
    set_req(0, 100, 7);
    set_req(1, 200, 9);
    set_req(2, 255, 16);
    set_req(3, 50, 51);
    do_reset();
    expect_op(0, 14, 2, 0);
    expect_op(1, 22, 2, 0);
    expect_op(2, 15, 15, 0);
    expect_op(3, 0, 50, 0);
    expect_op(0, 14, 2, 0);
    for (int i = 0; i < 5; i++) begin
      wait_accept((i == 4) ? 2 : 0, acc);
      wait_rsp(rc);
    end

    // Response backpressure with another request waiting.
    bus.rsp_ready = 1'b0;
    set_req(1, 60, 7);
    expect_op(1, 8, 4, 0);
    wait_accept(1, acc);
    set_req(3, 10, 3);
    expect_op(3, 3, 1, 0);
    wait_rsp(rc);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
      chk("bp_hold", 64'({bus.rsp_id, bus.rsp_q, bus.rsp_r, bus.rsp_err}),
          64'({2'd1, 8'd8, 8'd4, 1'b0}));
      chk("bp_no_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_released", 64'(bus.rsp_valid), 64'd0);
    wait_accept(1, acc);
    wait_rsp(rc);

    // Divide by zero.
    set_req(2, 37, 0);
`ifdef DIV_ARB_ZERO_CHECK_EN
    expect_op(2, 255, 37, 1);
`else
    expect_op(2, 255, 37, 0);
`endif
    s0 = n_start;
    wait_accept(1, acc);
    wait_rsp(rc);
`ifdef DIV_ARB_ZERO_CHECK_EN
    chk("dz_no_start", 64'(n_start - s0), 64'd0);
    chk("dz_latency", 64'(rc - acc), 64'd1);
`else
    chk("dz_start", 64'(n_start - s0), 64'd1);
    chk("dz_latency", 64'(rc - acc), 64'(L + 2));
`endif

    // Timeout with a divider that never completes.
    m_hang = 1'b1;
    set_req(1, 77, 3);
    expect_op(1, 0, 0, 1);
    wait_accept(1, acc);
    wait_rsp(rc);
    chk("to_latency", 64'(rc - acc), 64'(TIMEOUT + 2));

    // Stale done level held high across the next op is not a completion.
    m_force = 1'b1;
    set_req(0, 200, 10);
    expect_op(0, 0, 0, 1);
    wait_accept(1, acc);
    wait_rsp(rc);
    chk("stale_latency", 64'(rc - acc), 64'(TIMEOUT + 2));
    m_force = 1'b0;
    m_hang  = 1'b0;
    set_req(3, 99, 5);
    expect_op(3, 19, 4, 0);
    wait_accept(1, acc);
    wait_rsp(rc);
    chk("recover_latency", 64'(rc - acc), 64'(L + 2));

    // Asynchronous reset in WAIT; the held request is re-granted afterwards.
    set_req(2, 90, 10);
    grant_q.push_back(2);
    expect_op(2, 9, 0, 0);
    wait_accept(0, acc);
    repeat (4) @(posedge clk);
    #2;
    chk("ar_busy_before", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    chk("ar_busy", 64'(bus.busy), 64'd0);
    chk("ar_outputs", 64'({bus.rsp_valid, bus.div_start, bus.rsp_err, bus.req_ready, bus.rsp_id,
                           bus.rsp_q, bus.rsp_r, bus.div_a, bus.div_b}), 64'd0);
    repeat (2) begin
      @(negedge clk);
      chk("ar_no_rsp", 64'(bus.rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    wait_accept(1, acc);
    wait_rsp(rc);
    chk("ar_latency", 64'(rc - acc), 64'(L + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
